// File: rtl/axi_arbiter_rr_r.sv
// Round-robin read-path arbiter: one-hot mux select with multi-outstanding tenures.
// Optional stall watchdog enabled by defining ARB_WATCHDOG_EN.
module axi_arbiter_rr_r #(
  parameter int NUM_MASTERS     = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int WDT_CYCLES      = 256,
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [NUM_MASTERS-1:0] m_arvalid,
  input  logic [NUM_MASTERS-1:0] m_arready,
  input  logic [NUM_MASTERS-1:0] m_rvalid,
  input  logic [NUM_MASTERS-1:0] m_rready,
  input  logic [NUM_MASTERS-1:0] m_rlast,
  output logic [NUM_MASTERS-1:0] m_rgrnt,
  output logic [NUM_MASTERS-1:0] m_ar_allow,
  output logic [IW-1:0]          grant_idx,
  output logic                   busy,
  output logic [3:0]             outstanding,
  output logic                   err_underflow,
  output logic                   wdt_timeout
);

  // state   | meaning
  // S_IDLE  | no owner, waiting for any ARVALID
  // S_GRANT | owner holds the mux until its reads drain
  typedef enum logic {S_IDLE, S_GRANT} state_t;

  localparam logic [3:0] MAX4 = 4'(MAX_OUTSTANDING);

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grnt;
  logic [IW-1:0]          r_idx;
  logic [IW-1:0]          r_ptr;
  logic                   r_busy;
  logic [3:0]             r_out;
  logic [3:0]             r_ten;
  logic                   r_unf;
  logic                   r_wdt;

  logic [IW-1:0]          w_win;
  logic                   w_found;
  int                     w_cand;
  logic [NUM_MASTERS-1:0] w_win_oh;
  logic [IW-1:0]          w_ptr_nx;
  logic                   w_ar_hs;
  logic                   w_rl_hs;
  logic                   w_rbeat;
  logic [3:0]             w_out_nx;
  logic [3:0]             w_ten_nx;
  logic                   w_rel_norm;
  logic                   w_wdt_fire;
  logic                   w_rel;

  assign m_rgrnt       = r_grnt;
  assign m_ar_allow    = r_grnt & {NUM_MASTERS{r_ten < MAX4}};
  assign grant_idx     = r_idx;
  assign busy          = r_busy;
  assign outstanding   = r_out;
  assign err_underflow = r_unf;
  assign wdt_timeout   = r_wdt;

  // Search upward from the pointer so the last owner is considered last.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_cand  = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      w_cand = int'(r_ptr) + i;
      if (w_cand >= NUM_MASTERS) w_cand = w_cand - NUM_MASTERS;
      if (!w_found && m_arvalid[w_cand]) begin
        w_found = 1'b1;
        w_win   = IW'(w_cand);
      end
    end
  end

  assign w_win_oh = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << w_win;
  assign w_ptr_nx = (w_win == IW'(NUM_MASTERS-1)) ? '0 : w_win + 1'b1;

  assign w_ar_hs = r_busy & m_arvalid[r_idx] & m_arready[r_idx] & m_ar_allow[r_idx];
  assign w_rbeat = r_busy & m_rvalid[r_idx] & m_rready[r_idx];
  assign w_rl_hs = w_rbeat & m_rlast[r_idx];

  always_comb begin
    w_out_nx = r_out;
    if (w_ar_hs && !w_rl_hs)                      w_out_nx = r_out + 4'd1;
    else if (!w_ar_hs && w_rl_hs && r_out != 4'd0) w_out_nx = r_out - 4'd1;
  end

  assign w_ten_nx   = w_ar_hs ? r_ten + 4'd1 : r_ten;
  assign w_rel_norm = r_busy && (w_out_nx == 4'd0) && (!m_arvalid[r_idx] || w_ten_nx == MAX4);
  assign w_rel      = w_rel_norm | w_wdt_fire;

`ifdef ARB_WATCHDOG_EN
  logic [15:0] r_wdt_cnt;

  assign w_wdt_fire = r_busy && !w_ar_hs && !w_rbeat && (r_wdt_cnt == 16'(WDT_CYCLES - 1));

  always_ff @(posedge ACLK) begin
    if (!ARESETn || !r_busy || w_rel || w_ar_hs || w_rbeat) r_wdt_cnt <= '0;
    else                                                    r_wdt_cnt <= r_wdt_cnt + 16'd1;
  end
`else
  // WDT_CYCLES has no effect without the watchdog; this keeps it referenced.
  assign w_wdt_fire = 1'b0 & (WDT_CYCLES != 0);
`endif

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state <= S_IDLE;
      r_grnt  <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_busy  <= 1'b0;
      r_out   <= '0;
      r_ten   <= '0;
      r_unf   <= 1'b0;
      r_wdt   <= 1'b0;
    end else begin
      r_unf <= w_rl_hs && (r_out == 4'd0);
      r_wdt <= w_wdt_fire;
      if (r_state == S_IDLE || w_rel) begin
        if (w_found) begin
          r_state <= S_GRANT;
          r_grnt  <= w_win_oh;
          r_idx   <= w_win;
          r_ptr   <= w_ptr_nx;
          r_busy  <= 1'b1;
          r_out   <= '0;
          r_ten   <= '0;
        end else if (w_rel) begin
          r_state <= S_IDLE;
          r_grnt  <= '0;
          r_busy  <= 1'b0;
          r_out   <= '0;
          r_ten   <= '0;
        end
      end else begin
        r_out <= w_out_nx;
        r_ten <= w_ten_nx;
      end
    end
  end

endmodule

// File: tb/tb_axi_arbiter_rr_r.sv
// Bench for axi_arbiter_rr_r: directed scenarios plus random traffic against a tenure-level model.
module tb_axi_arbiter_rr_r;
  localparam int N    = 4;
  localparam int MAXO = 4;
  localparam int WDT  = 16;

  logic         ACLK = 1'b0;
  logic         ARESETn;
  logic [N-1:0] m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [N-1:0] m_rgrnt, m_ar_allow;
  logic [1:0]   grant_idx;
  logic         busy;
  logic [3:0]   outstanding;
  logic         err_underflow, wdt_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // model state: owner (-1 = none), counts, pointer, last index, stall count
  int mo, mout, mten, mptr, midx, mst;
  bit munf, mwdt;

  axi_arbiter_rr_r #(.NUM_MASTERS(N), .MAX_OUTSTANDING(MAXO), .WDT_CYCLES(WDT)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast),
    .m_rgrnt(m_rgrnt), .m_ar_allow(m_ar_allow), .grant_idx(grant_idx),
    .busy(busy), .outstanding(outstanding),
    .err_underflow(err_underflow), .wdt_timeout(wdt_timeout)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_grant(input logic [N-1:0] arv);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (mptr + k) % N;
      if (arv[c]) begin
        mo = c; midx = c; mptr = (c + 1) % N;
        mout = 0; mten = 0; mst = 0;
        return;
      end
    end
  endtask

  task automatic model_step(input bit rst, input logic [N-1:0] arv, arr, rv, rr, rl);
    int ar, rlh, beat, on, tn;
    bit rel;
    if (!rst) begin
      mo = -1; mout = 0; mten = 0; mptr = 0; midx = 0; mst = 0; munf = 0; mwdt = 0;
      return;
    end
    munf = 0; mwdt = 0;
    if (mo < 0) begin
      if (arv != 0) model_grant(arv);
      return;
    end
    ar   = (arv[mo] && arr[mo] && mten < MAXO) ? 1 : 0;
    beat = (rv[mo] && rr[mo]) ? 1 : 0;
    rlh  = (beat == 1 && rl[mo]) ? 1 : 0;
    munf = (rlh == 1 && mout == 0);
    if (ar == 1 && rlh == 1) on = mout;
    else on = mout + ar - rlh;
    if (on < 0) on = 0;
    tn  = mten + ar;
    rel = (on == 0) && (!arv[mo] || tn == MAXO);
`ifdef ARB_WATCHDOG_EN
    if (ar == 1 || beat == 1) mst = 0;
    else if (mst == WDT - 1) begin
      rel = 1; mwdt = 1; on = 0; tn = 0;
    end else mst++;
`endif
    if (rel) begin
      if (arv != 0) model_grant(arv);
      else begin
        mo = -1; mout = 0; mten = 0;
      end
    end else begin
      mout = on; mten = tn;
    end
  endtask

  task automatic check_model();
    logic [31:0] eg, ea;
    eg = (mo >= 0) ? (32'd1 << mo) : 32'd0;
    ea = (mo >= 0 && mten < MAXO) ? eg : 32'd0;
    chk("rgrnt", 32'(m_rgrnt), eg);
    chk("ar_allow", 32'(m_ar_allow), ea);
    chk("grant_idx", 32'(grant_idx), 32'(midx));
    chk("busy", 32'(busy), 32'(mo >= 0));
    chk("outstanding", 32'(outstanding), 32'(mout));
    chk("err_underflow", 32'(err_underflow), 32'(munf));
    chk("wdt_timeout", 32'(wdt_timeout), 32'(mwdt));
  endtask

  task automatic tick(input bit rst, input logic [N-1:0] arv, arr, rv, rr, rl);
    ARESETn = rst; m_arvalid = arv; m_arready = arr;
    m_rvalid = rv; m_rready = rr; m_rlast = rl;
    @(posedge ACLK);
    model_step(rst, arv, arr, rv, rr, rl);
    @(negedge ACLK);
    check_model();
  endtask

  initial begin
    logic [N-1:0] oh, arv, arr, rv, rr, rl;
    int o;
    ARESETn = 1'b0; m_arvalid = '0; m_arready = '0;
    m_rvalid = '0; m_rready = '0; m_rlast = '0;
    mo = -1; mout = 0; mten = 0; mptr = 0; midx = 0; mst = 0; munf = 0; mwdt = 0;

    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    repeat (10) tick(1, 0, 0, 0, 0, 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_grnt", 32'(m_rgrnt), 0);

    // all masters request; one AR and one single-beat read each
    tick(1, 4'hF, 4'hF, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      o  = k % N;
      oh = 4'b0001 << o;
      chk("rot_idx", 32'(grant_idx), 32'(o));
      chk("rot_busy", 32'(busy), 1);
      tick(1, 4'hF, 4'hF, 0, 0, 0);
      tick(1, ~oh, 4'hF, oh, oh, oh);
    end

    // master 2 alone, three ARs then three RLASTs
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 4'b0100, 4'b0100, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      tick(1, 4'b0100, 4'b0100, 0, 0, 0);
      chk("m2_out_up", 32'(outstanding), 32'(i));
    end
    for (int i = 2; i >= 0; i--) begin
      tick(1, 0, 0, 4'b0100, 4'b0100, 4'b0100);
      chk("m2_out_dn", 32'(outstanding), 32'(i));
    end
    chk("m2_released", 32'(busy), 0);

    // tenure cap: master 1 keeps asking, master 3 waits
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 4'b1010, 4'hF, 0, 0, 0);
    repeat (4) tick(1, 4'b1010, 4'hF, 0, 0, 0);
    chk("cap_allow1", 32'(m_ar_allow[1]), 0);
    chk("cap_grnt_held", 32'(m_rgrnt), 32'h2);
    chk("cap_out", 32'(outstanding), 4);
    repeat (4) tick(1, 4'b1010, 4'hF, 4'b0010, 4'b0010, 4'b0010);
    chk("cap_next_owner", 32'(grant_idx), 3);
    chk("cap_next_grnt", 32'(m_rgrnt), 32'h8);

    // underflow on owner 3
    tick(1, 4'b1010, 0, 4'b1000, 4'b1000, 4'b1000);
    chk("unf_pulse", 32'(err_underflow), 1);
    chk("unf_out", 32'(outstanding), 0);
    tick(1, 4'b1010, 0, 0, 0, 0);
    chk("unf_clear", 32'(err_underflow), 0);

`ifdef ARB_WATCHDOG_EN
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 4'b0001, 4'b0001, 0, 0, 0);
    tick(1, 4'b0001, 4'b0001, 0, 0, 0);
    repeat (15) tick(1, 4'b0100, 0, 0, 0, 0);
    chk("wdt_hold", 32'(grant_idx), 0);
    tick(1, 4'b0100, 0, 0, 0, 0);
    chk("wdt_pulse", 32'(wdt_timeout), 1);
    chk("wdt_next", 32'(grant_idx), 2);
`endif

    // reset mid-burst
    tick(1, 4'b0100, 4'b0100, 0, 0, 0);
    tick(0, 4'b0100, 4'b0100, 0, 0, 0);
    chk("rst_grnt", 32'(m_rgrnt), 0);
    chk("rst_out", 32'(outstanding), 0);

    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        arv[i] = ($urandom_range(0, 3) != 0);
        arr[i] = ($urandom_range(0, 1) != 0);
        rv[i]  = ($urandom_range(0, 1) != 0);
        rr[i]  = ($urandom_range(0, 3) != 0);
        rl[i]  = ($urandom_range(0, 1) != 0);
      end
      tick(($urandom_range(0, 299) != 0), arv, arr, rv, rr, rl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
